// File: rtl/timer_cmp_irq_pkg.sv
// Shared constants and FSM state type for the timer compare/interrupt block.
package timer_cmp_irq_pkg;

    localparam logic [3:0] ADDR_CMP    = 4'h1;
    localparam logic [3:0] ADDR_CTRL   = 4'h2;
    localparam logic [3:0] ADDR_STATUS = 4'h3;
    localparam logic [3:0] ADDR_CAP    = 4'h4;

    localparam int unsigned CTRL_EN   = 0;
    localparam int unsigned CTRL_PER  = 1;
    localparam int unsigned CTRL_IE   = 2;
    localparam int unsigned STAT_PEND = 0;
    localparam int unsigned STAT_OVR  = 1;

    localparam logic [15:0] CMP_RST = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/timer_cmp_irq_if.sv
// Peripheral register bus between the CPU side and the compare block.
interface timer_cmp_irq_if;

    logic [15:0] addr;
    logic [15:0] wdata;
    logic        we;
    logic [15:0] rdata;

    modport master (output addr, output wdata, output we, input rdata);
    modport slave  (input addr, input wdata, input we, output rdata);

endinterface

// File: rtl/timer_cmp_edge_det.sv
// Registered rising-edge detector; o_rise pulses one cycle after i_sig rises.
module timer_cmp_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic i_sig,
    output logic o_rise
);

    logic r_prev;
    logic r_rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_prev <= i_sig;
            r_rise <= i_sig & ~r_prev;
        end
    end

    assign o_rise = r_rise;

endmodule

// File: rtl/timer_cmp_irq.sv
// Compare-match interrupt peripheral: CMP/CTRL/STATUS registers, match FSM.
// Optional capture register enabled by defining TIMER_CMP_CAPTURE_EN.
module timer_cmp_irq
    import timer_cmp_irq_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    timer_cmp_irq_if.slave       bus,
    input  logic [15:0]          count,
    output logic                 irq,
`ifdef TIMER_CMP_CAPTURE_EN
    input  logic                 cap_in,
`endif
    input  logic                 irq_ack
);

    state_t      r_state;
    logic [15:0] r_cmp;
    logic        r_en;
    logic        r_per;
    logic        r_ie;
    logic        r_pend;
    logic        r_ovr;

    logic [3:0]  w_off;
    logic        w_wr_cmp;
    logic        w_wr_ctrl;
    logic        w_wr_stat;
    logic        w_match;
    logic        w_clr_pend;
    logic        w_clr_ovr;
    logic        w_unused;

    assign w_off      = bus.addr[3:0];
    assign w_wr_cmp   = bus.we && (w_off == ADDR_CMP);
    assign w_wr_ctrl  = bus.we && (w_off == ADDR_CTRL);
    assign w_wr_stat  = bus.we && (w_off == ADDR_STATUS);
    assign w_match    = (r_state == S_ARMED) && (count == r_cmp);
    assign w_clr_pend = irq_ack || (w_wr_stat && bus.wdata[STAT_PEND]);
    assign w_clr_ovr  = w_wr_stat && bus.wdata[STAT_OVR];
    assign w_unused   = &{1'b0, bus.addr[15:4]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cmp   <= CMP_RST;
            r_en    <= 1'b0;
            r_per   <= 1'b0;
            r_ie    <= 1'b0;
            r_pend  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            if (w_wr_cmp)
                r_cmp <= bus.wdata;

            if (w_wr_ctrl) begin
                r_en  <= bus.wdata[CTRL_EN];
                r_per <= bus.wdata[CTRL_PER];
                r_ie  <= bus.wdata[CTRL_IE];
            end else if (w_match && !r_per) begin
                r_en <= 1'b0;
            end

            // Register writes take priority over the match-driven transitions.
            if (w_wr_ctrl && !bus.wdata[CTRL_EN]) begin
                r_state <= S_IDLE;
            end else if (w_wr_ctrl && (r_state == S_IDLE)) begin
                r_state <= S_ARMED;
            end else if (w_wr_cmp && (r_state != S_IDLE)) begin
                r_state <= S_ARMED;
            end else begin
                case (r_state)
                    S_ARMED: if (w_match) r_state <= r_per ? S_HOLD : S_IDLE;
                    S_HOLD:  if (count != r_cmp) r_state <= S_ARMED;
                    default: r_state <= r_state;
                endcase
            end

            // A match beats a same-cycle clear, and then does not count as overrun.
            if (w_match)
                r_pend <= 1'b1;
            else if (w_clr_pend)
                r_pend <= 1'b0;

            if (w_match && r_pend && !w_clr_pend)
                r_ovr <= 1'b1;
            else if (w_clr_ovr)
                r_ovr <= 1'b0;
        end
    end

    assign irq = r_pend & r_ie;

`ifdef TIMER_CMP_CAPTURE_EN
    logic        w_cap_rise;
    logic [15:0] r_cap;

    timer_cmp_edge_det u_edge_det (
        .clk    (clk),
        .rst    (rst),
        .i_sig  (cap_in),
        .o_rise (w_cap_rise)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cap <= '0;
        else if (w_cap_rise)
            r_cap <= count;
    end
`endif

    always_comb begin
        bus.rdata = '0;
        case (w_off)
            ADDR_CMP:    bus.rdata = r_cmp;
            ADDR_CTRL:   bus.rdata = {13'd0, r_ie, r_per, r_en};
            ADDR_STATUS: bus.rdata = {14'd0, r_ovr, r_pend};
`ifdef TIMER_CMP_CAPTURE_EN
            ADDR_CAP:    bus.rdata = r_cap;
`endif
            default:     bus.rdata = '0;
        endcase
    end

endmodule

// File: doc/timer_cmp_irq.md
TIMER_CMP_IRQ -- requirements
Module: timer_cmp_irq

Interface
REQ-001 clk  in  1  system clock; all state changes on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-high.
REQ-003 addr  in  16  peripheral bus address; only addr[3:0] decoded.
REQ-004 wdata  in  16  bus write data.
REQ-005 we  in  1  bus write strobe, one cycle per write.
REQ-006 rdata  out  16  combinational read data; 16'h0 for any undecoded offset, including 4'h0, so it can be ORed with the timer's rdata.
REQ-007 count  in  16  live counter value from the timer block.
REQ-008 irq  out  1  level interrupt request = STATUS.PEND & CTRL.IE.
REQ-009 irq_ack  in  1  one-cycle CPU acknowledge; clears PEND.
REQ-010 cap_in  in  1  external capture event; present only with TIMER_CMP_CAPTURE_EN.

Function
REQ-011 Register map (addr[3:0]): 4'h1 CMP (R/W, 16 b); 4'h2 CTRL (R/W: bit0 EN, bit1 PERIODIC, bit2 IE, others read 0); 4'h3 STATUS (bit0 PEND, bit1 OVR; write-1-to-clear); 4'h4 CAP (RO, macro only).
REQ-012 FSM states: IDLE, ARMED, HOLD.
REQ-013 IDLE -> ARMED on the cycle a CTRL write sets EN=1; any CTRL write with EN=0 forces IDLE from every state.
REQ-014 Match = state ARMED and count == CMP, evaluated each cycle; PEND = 1 in the following cycle (1-cycle latency); irq asserts in that same cycle if IE=1.
REQ-015 On match, one-shot (PERIODIC=0): EN cleared, next state IDLE; periodic: next state HOLD.
REQ-016 HOLD -> ARMED on the first cycle with count != CMP; no further match while in HOLD.
REQ-017 Match while PEND already 1 sets OVR; PEND stays 1.
REQ-018 PEND cleared by irq_ack=1 or by STATUS write with wdata[0]=1; OVR cleared only by STATUS write with wdata[1]=1.
REQ-019 Simultaneous match and PEND clear (ack or W1C): set wins, PEND=1, OVR not set.
REQ-020 CMP write while ARMED or HOLD: new value used from the next cycle, next state ARMED.
REQ-021 Writes to undecoded offsets have no effect; comparison is exact 16-bit equality, so count wrap 16'hFFFF->16'h0000 needs no special handling and CMP=16'h0000 matches after wrap.

Reset
REQ-022 On rst: CMP=16'hFFFF, CTRL=0, PEND=0, OVR=0, CAP=0, state IDLE, irq=0; reset mid-operation discards any pending match.

Configuration
REQ-023 TIMER_CMP_CAPTURE_EN defined: cap_in rising edge (registered, sampled against previous value) latches count into CAP one cycle later; a capture on the same cycle as a CAP read returns the old value.
REQ-024 TIMER_CMP_CAPTURE_EN undefined: cap_in port, CAP register and edge detector absent; offset 4'h4 reads 16'h0.

Structure
REQ-025 Shared package holds register offset constants, CTRL/STATUS bit-index constants, FSM state enum and CMP reset value.
REQ-026 One sub-module, timer_cmp_edge_det (rising-edge detector for cap_in), instantiated only under the macro; everything else stays in timer_cmp_irq.

Verification
REQ-027 CMP=16'h0010, CTRL=3'b101 (one-shot, IE), count ramps from 0 -> PEND and irq high the cycle after count=16'h0010; CTRL reads 3'b100; no second irq after wrap.
REQ-028 CMP=16'h0005, CTRL=3'b111, count ramps and wraps -> one match per pass; count held at 16'h0005 for 4 cycles gives exactly one PEND set.
REQ-029 Match with PEND=1 and no ack -> OVR=1; STATUS write 16'h0002 clears only OVR; irq_ack clears PEND and deasserts irq next cycle.
REQ-030 irq_ack asserted in the exact match cycle -> PEND remains 1, OVR=0.
REQ-031 rst asserted while ARMED with count one below CMP -> no PEND and no irq after reset release; CMP reads 16'hFFFF.
REQ-032 With macro: cap_in pulse when count=16'h1234 -> CAP reads 16'h1234; without macro offset 4'h4 reads 16'h0000.
